// File: rtl/video_pkg.sv
// Shared video definitions: raster coordinate widths, capture FSM states and
// the 24-bit to 8-bit pixel mappings used by capture and the display color maps.
package video_pkg;

    localparam int unsigned H_BITS    = 11;
    localparam int unsigned V_BITS    = 10;
    localparam int unsigned PIX_BITS  = 24;
    localparam int unsigned DATA_BITS = 8;
    localparam int unsigned SUM_BITS  = 10;

    localparam logic [SUM_BITS-1:0] MONO_THRESHOLD = SUM_BITS'(384);

    typedef enum logic [1:0] {
        CAP_IDLE    = 2'd0,
        CAP_ARMED   = 2'd1,
        CAP_CAPTURE = 2'd2,
        CAP_DONE    = 2'd3
    } cap_state_e;

    // Packed {R,G,B} pixel as it appears on the video output mux.
    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_pixel_t;

    // RGB332: keep the top 3/3/2 bits of each channel.
    function automatic logic [DATA_BITS-1:0] rgb332(input rgb_pixel_t p);
        return {p.r[7:5], p.g[7:5], p.b[7:6]};
    endfunction

    // Monochrome: full-on when the channel sum reaches the threshold.
    function automatic logic [DATA_BITS-1:0] mono_threshold(input rgb_pixel_t p);
        logic [SUM_BITS-1:0] sum;
        sum = SUM_BITS'(p.r) + SUM_BITS'(p.g) + SUM_BITS'(p.b);
        return (sum >= MONO_THRESHOLD) ? DATA_BITS'(8'hFF) : DATA_BITS'(8'h00);
    endfunction

endpackage

// File: rtl/screen_capture_if.sv
// Write port of the dual-port image RAM driven by screen_capture.
interface screen_capture_if #(
    parameter int unsigned ADDR_W = 16
);
    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic [7:0]        wdata;

    modport master (output we, output waddr, output wdata);
    modport slave  (input  we, input  waddr, input  wdata);
endinterface

// File: rtl/screen_capture_pixel_map.sv
// capture_pixel_map: combinational 24-bit pixel to 8-bit RAM word.
// Build option CAPTURE_THRESHOLD_EN selects the monochrome threshold format;
// otherwise the word is RGB332.
module capture_pixel_map
    import video_pkg::*;
(
    input  logic [PIX_BITS-1:0]  pixel,
    output logic [DATA_BITS-1:0] data_c
);

    rgb_pixel_t pix;

    // Select the stored pixel format.
    always_comb begin
        pix = rgb_pixel_t'(pixel);
`ifdef CAPTURE_THRESHOLD_EN
        data_c = mono_threshold(pix);
`else
        data_c = rgb332(pix);
`endif
    end

endmodule

// File: rtl/screen_capture.sv
// screen_capture: writes a WIDTH x HEIGHT window of the live raster, starting
// at the (x, y) latched on the frame start after arm, into an 8-bit image RAM
// in raster order. Pixel format depends on CAPTURE_THRESHOLD_EN (see
// capture_pixel_map).
module screen_capture
    import video_pkg::*;
#(
    parameter int unsigned WIDTH  = 72,
    parameter int unsigned HEIGHT = 512,
    parameter int unsigned ADDR_W = 16
) (
    input  logic                 pixel_clk,
    input  logic                 reset,
    input  logic [H_BITS-1:0]    x,
    input  logic [V_BITS-1:0]    y,
    input  logic [H_BITS-1:0]    hcount,
    input  logic [V_BITS-1:0]    vcount,
    input  logic [PIX_BITS-1:0]  pixel,
    input  logic                 arm,
    output logic                 busy,
    output logic                 done,
    screen_capture_if.master     ram
);

    localparam int unsigned XE_BITS = H_BITS + 1;
    localparam int unsigned YE_BITS = V_BITS + 1;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(WIDTH * HEIGHT - 1);

    cap_state_e             state_q, state_d;
    logic [H_BITS-1:0]      xr_q, xr_d;
    logic [V_BITS-1:0]      yr_q, yr_d;
    logic [ADDR_W-1:0]      cnt_q, cnt_d;
    logic                   last_q, last_d;
    logic                   we_q, we_d;
    logic [ADDR_W-1:0]      waddr_q, waddr_d;
    logic [DATA_BITS-1:0]   wdata_q, wdata_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;

    logic [DATA_BITS-1:0]   map_data_c;
    logic                   frame_start;
    logic                   eval;
    logic                   in_win;
    logic                   wr;
    logic [H_BITS-1:0]      win_x;
    logic [V_BITS-1:0]      win_y;
    logic [ADDR_W-1:0]      base;
    logic [XE_BITS-1:0]     h_e, x_lo, x_hi;
    logic [YE_BITS-1:0]     v_e, y_lo, y_hi;

    capture_pixel_map u_map (
        .pixel  (pixel),
        .data_c (map_data_c)
    );

    // Next state, window compare, address counter and registered outputs.
    always_comb begin
        state_d = state_q;
        xr_d    = xr_q;
        yr_d    = yr_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        win_x   = xr_q;
        win_y   = yr_q;
        base    = cnt_q;
        eval    = 1'b0;

        frame_start = (hcount == '0) && (vcount == '0);

        case (state_q)
            CAP_IDLE: begin
                if (arm) begin
                    state_d = CAP_ARMED;
                end
            end
            CAP_ARMED: begin
                // The frame-start pixel is judged against the freshly latched origin.
                if (frame_start) begin
                    xr_d    = x;
                    yr_d    = y;
                    win_x   = x;
                    win_y   = y;
                    base    = '0;
                    cnt_d   = '0;
                    last_d  = 1'b0;
                    eval    = 1'b1;
                    state_d = CAP_CAPTURE;
                end
            end
            CAP_CAPTURE: begin
                // last_q: final address already written; frame_start: window clipped.
                if (frame_start || last_q) begin
                    state_d = CAP_DONE;
                end else begin
                    eval = 1'b1;
                end
            end
            CAP_DONE: begin
                last_d  = 1'b0;
                state_d = CAP_IDLE;
            end
            default: begin
                state_d = CAP_IDLE;
            end
        endcase

        // Widened bounds so x+WIDTH and y+HEIGHT never wrap.
        h_e  = XE_BITS'(hcount);
        x_lo = XE_BITS'(win_x);
        x_hi = x_lo + XE_BITS'(WIDTH);
        v_e  = YE_BITS'(vcount);
        y_lo = YE_BITS'(win_y);
        y_hi = y_lo + YE_BITS'(HEIGHT);

        in_win = (h_e >= x_lo) && (h_e < x_hi) && (v_e >= y_lo) && (v_e < y_hi);
        wr     = eval && in_win;

        if (wr) begin
            cnt_d = base + ADDR_W'(1);
            if (base == LAST_ADDR) begin
                last_d = 1'b1;
            end
        end

        we_d    = wr;
        waddr_d = wr ? base : waddr_q;
        wdata_d = wr ? map_data_c : wdata_q;
        busy_d  = (state_d == CAP_ARMED) || (state_d == CAP_CAPTURE);
        done_d  = (state_d == CAP_DONE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge pixel_clk) begin
        if (reset) begin
            state_q <= CAP_IDLE;
            xr_q    <= '0;
            yr_q    <= '0;
            cnt_q   <= '0;
            last_q  <= 1'b0;
            we_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            xr_q    <= xr_d;
            yr_q    <= yr_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            we_q    <= we_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign ram.we    = we_q;
    assign ram.waddr = waddr_q;
    assign ram.wdata = wdata_q;

endmodule

// File: tb/tb_screen_capture.sv
// Directed bench for screen_capture: a 4x2 window instance and a 4x8 window
// instance share the raster inputs; hcount/vcount are driven directly.
module tb_screen_capture;

    logic        clk;
    logic        rst_a, rst_b;
    logic        arm_a, arm_b;
    logic [10:0] x;
    logic [9:0]  y;
    logic [10:0] hcount;
    logic [9:0]  vcount;
    logic [23:0] pixel;
    logic        busy_a, done_a, busy_b, done_b;

    int total;
    int bad;

`ifdef CAPTURE_THRESHOLD_EN
    localparam logic [7:0] EXP_WHITE = 8'hFF;
    localparam logic [7:0] EXP_E0C080 = 8'hFF;
    localparam logic [7:0] EXP_404040 = 8'h00;
`else
    localparam logic [7:0] EXP_WHITE = 8'hFF;
    localparam logic [7:0] EXP_E0C080 = 8'hFA;
    localparam logic [7:0] EXP_404040 = 8'h49;
`endif

    screen_capture_if #(.ADDR_W(16)) ram_a ();
    screen_capture_if #(.ADDR_W(16)) ram_b ();

    screen_capture #(.WIDTH(4), .HEIGHT(2), .ADDR_W(16)) dut_a (
        .pixel_clk (clk),
        .reset     (rst_a),
        .x         (x),
        .y         (y),
        .hcount    (hcount),
        .vcount    (vcount),
        .pixel     (pixel),
        .arm       (arm_a),
        .busy      (busy_a),
        .done      (done_a),
        .ram       (ram_a)
    );

    screen_capture #(.WIDTH(4), .HEIGHT(8), .ADDR_W(16)) dut_b (
        .pixel_clk (clk),
        .reset     (rst_b),
        .x         (x),
        .y         (y),
        .hcount    (hcount),
        .vcount    (vcount),
        .pixel     (pixel),
        .arm       (arm_b),
        .busy      (busy_b),
        .done      (done_b),
        .ram       (ram_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Inputs set before the edge; outputs read 1ns after describe that cycle.
    task automatic pix(input int h, input int v);
        hcount = 11'(h);
        vcount = 10'(v);
        @(posedge clk);
        #1;
    endtask

    initial begin
        total  = 0;
        bad    = 0;
        rst_a  = 1'b1;
        rst_b  = 1'b1;
        arm_a  = 1'b0;
        arm_b  = 1'b0;
        x      = 11'd10;
        y      = 10'd5;
        pixel  = 24'hFFFFFF;
        pix(100, 100);
        pix(100, 100);

        chk("reset_busy", 32'(busy_a), 32'd0);
        chk("reset_done", 32'(done_a), 32'd0);
        chk("reset_we", 32'(ram_a.we), 32'd0);
        chk("reset_waddr", 32'(ram_a.waddr), 32'd0);
        chk("reset_wdata", 32'(ram_a.wdata), 32'd0);
        rst_a = 1'b0;
        rst_b = 1'b0;

        // Basic 4x2 capture at (10,5) with arm pulsed mid-capture.
        arm_a = 1'b1;
        pix(100, 100);
        arm_a = 1'b0;
        chk("armed_busy", 32'(busy_a), 32'd1);
        pix(0, 0);
        chk("fs_no_write", 32'(ram_a.we), 32'd0);
        pix(9, 5);
        chk("left_of_win", 32'(ram_a.we), 32'd0);
        for (int v = 5; v <= 6; v++) begin
            for (int h = 10; h <= 13; h++) begin
                arm_a = (v == 5 && h == 11);
                pix(h, v);
                chk("basic_we", 32'(ram_a.we), 32'd1);
                chk("basic_waddr", 32'(ram_a.waddr), 32'((v - 5) * 4 + (h - 10)));
                chk("basic_wdata", 32'(ram_a.wdata), 32'(EXP_WHITE));
                chk("basic_no_done", 32'(done_a), 32'd0);
                chk("basic_busy", 32'(busy_a), 32'd1);
            end
        end
        arm_a = 1'b0;
        pix(14, 6);
        chk("end_done", 32'(done_a), 32'd1);
        chk("end_we", 32'(ram_a.we), 32'd0);
        chk("end_busy", 32'(busy_a), 32'd0);
        arm_a = 1'b1;
        pix(100, 100);
        arm_a = 1'b0;
        chk("done_pulse", 32'(done_a), 32'd0);
        pix(100, 100);
        chk("arm_on_done_ign", 32'(busy_a), 32'd0);
        pix(0, 0);
        pix(10, 5);
        chk("idle_no_write", 32'(ram_a.we), 32'd0);
        chk("idle_no_done", 32'(done_a), 32'd0);

        // Pixel mapping, then reset after three writes.
        arm_a = 1'b1;
        pix(100, 100);
        arm_a = 1'b0;
        pix(0, 0);
        pixel = 24'hE0C080;
        pix(10, 5);
        chk("map_e0c080", 32'(ram_a.wdata), 32'(EXP_E0C080));
        chk("map_addr0", 32'(ram_a.waddr), 32'd0);
        pixel = 24'h404040;
        pix(11, 5);
        chk("map_404040", 32'(ram_a.wdata), 32'(EXP_404040));
        pixel = 24'hFFFFFF;
        pix(12, 5);
        chk("pre_rst_waddr", 32'(ram_a.waddr), 32'd2);
        rst_a = 1'b1;
        pix(13, 5);
        rst_a = 1'b0;
        chk("rst_we", 32'(ram_a.we), 32'd0);
        chk("rst_busy", 32'(busy_a), 32'd0);
        chk("rst_waddr", 32'(ram_a.waddr), 32'd0);
        chk("rst_done", 32'(done_a), 32'd0);
        pix(10, 6);
        chk("post_rst_we", 32'(ram_a.we), 32'd0);
        pix(0, 0);
        pix(10, 5);
        chk("post_rst_idle_we", 32'(ram_a.we), 32'd0);
        chk("post_rst_done", 32'(done_a), 32'd0);

        // Fresh capture restarts at 0; x changes after the latch are ignored.
        arm_a = 1'b1;
        pix(100, 100);
        arm_a = 1'b0;
        pix(0, 0);
        pix(10, 5);
        chk("restart_we", 32'(ram_a.we), 32'd1);
        chk("restart_addr0", 32'(ram_a.waddr), 32'd0);
        x = 11'd50;
        for (int h = 11; h <= 13; h++) begin
            pix(h, 5);
            chk("latch_we", 32'(ram_a.we), 32'd1);
            chk("latch_waddr", 32'(ram_a.waddr), 32'(h - 10));
        end
        pix(50, 5);
        chk("latch_new_x_ign", 32'(ram_a.we), 32'd0);
        pix(10, 6);
        chk("latch_row2_addr", 32'(ram_a.waddr), 32'd4);
        chk("latch_row2_we", 32'(ram_a.we), 32'd1);
        rst_a = 1'b1;
        pix(100, 100);
        rst_a = 1'b0;
        x = 11'd10;

        // Clipped 4x8 window at y=1020: only lines 1020..1023 exist.
        y = 10'd1020;
        arm_b = 1'b1;
        pix(100, 100);
        arm_b = 1'b0;
        pix(0, 0);
        chk("clip_fs_we", 32'(ram_b.we), 32'd0);
        for (int v = 1020; v <= 1023; v++) begin
            for (int h = 10; h <= 13; h++) begin
                pix(h, v);
                chk("clip_we", 32'(ram_b.we), 32'd1);
                chk("clip_waddr", 32'(ram_b.waddr), 32'((v - 1020) * 4 + (h - 10)));
            end
            pix(20, v);
            chk("clip_gap_we", 32'(ram_b.we), 32'd0);
            chk("clip_busy", 32'(busy_b), 32'd1);
            chk("clip_no_done", 32'(done_b), 32'd0);
        end
        pix(0, 0);
        chk("clip_done", 32'(done_b), 32'd1);
        chk("clip_end_we", 32'(ram_b.we), 32'd0);
        chk("clip_end_busy", 32'(busy_b), 32'd0);
        pix(100, 100);
        chk("clip_done_pulse", 32'(done_b), 32'd0);
        chk("clip_a_idle", 32'(busy_a), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
